// File: rtl/sram_byte_ctrl_if.sv
// Word-wide request/response bus between a bus master and the byte-wide SRAM controller.
// The master holds valid_i with stable fields until ready_o pulses.
interface sram_byte_ctrl_if;
    logic        valid_i;
    logic        ready_o;
    logic [18:0] addr_i;
    logic [3:0]  wstrb_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;

    modport master (
        output valid_i, addr_i, wstrb_i, write_data_i,
        input  ready_o, read_data_o
    );

    modport slave (
        input  valid_i, addr_i, wstrb_i, write_data_i,
        output ready_o, read_data_o
    );
endinterface

// File: rtl/sram_byte_ctrl.sv
// Converts 32-bit word requests into sequences of byte accesses on an asynchronous 8-bit SRAM.
// Reads walk lanes 0..3 back-to-back; writes visit only strobed lanes, each followed by a recovery cycle.
module sram_byte_ctrl #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sram_byte_ctrl_if.slave   bus,
    output logic [18:0]       mem_addr_o,
    input  logic [7:0]        mem_dq_i,
    output logic [7:0]        mem_dq_o,
    output logic              mem_dq_oe_o,
    output logic              mem_ce_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_next;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  pend_q;
    logic        is_write_q;
    logic [1:0]  lane_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;

    logic        last_access;
    logic [3:0]  pend_rest;

    function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    assign last_access = (cnt_q == CNT_LAST);
    // Strobed lanes still to be written once the current lane retires.
    assign pend_rest   = pend_q & ~(4'b0001 << lane_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.valid_i) state_next = ACCESS;
            ACCESS:  if (last_access) begin
                         if (is_write_q)          state_next = RECOVER;
                         else if (lane_q == 2'd3) state_next = DONE;
                     end
            RECOVER: state_next = (pend_rest != 4'b0000) ? ACCESS : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q     <= '0;
            wdata_q    <= '0;
            pend_q     <= '0;
            is_write_q <= 1'b0;
            lane_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.valid_i) begin
                    word_q     <= bus.addr_i[18:2];
                    wdata_q    <= bus.write_data_i;
                    pend_q     <= bus.wstrb_i;
                    is_write_q <= |bus.wstrb_i;
                    lane_q     <= (|bus.wstrb_i) ? lowest_lane(bus.wstrb_i) : 2'd0;
                    cnt_q      <= '0;
                end
                ACCESS: if (last_access) begin
                    cnt_q <= '0;
                    if (!is_write_q) begin
                        rdata_q[{lane_q, 3'b000} +: 8] <= mem_dq_i;
                        lane_q                         <= lane_q + 2'd1;
                    end
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                RECOVER: begin
                    pend_q <= pend_rest;
                    if (pend_rest != 4'b0000) lane_q <= lowest_lane(pend_rest);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o      = {word_q, lane_q};
    assign mem_dq_o        = wdata_q[{lane_q, 3'b000} +: 8];
    assign bus.read_data_o = rdata_q;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_ce_n_o  = 1'b1;
        mem_oe_n_o  = 1'b1;
        mem_we_n_o  = 1'b1;
        mem_dq_oe_o = 1'b0;
        bus.ready_o = 1'b0;
        unique case (state)
            ACCESS: begin
                mem_ce_n_o = 1'b0;
                if (is_write_q) begin
                    mem_we_n_o  = 1'b0;
                    mem_dq_oe_o = 1'b1;
                end else begin
                    mem_oe_n_o = 1'b0;
                end
            end
            RECOVER: begin
                mem_ce_n_o  = 1'b0;
                mem_dq_oe_o = 1'b1;
            end
            DONE:    bus.ready_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/sram_byte_ctrl.md
SRAM_BYTE_CTRL -- requirements
Module: sram_byte_ctrl

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2: clock cycles each SRAM byte strobe is held active; legal range 1..15.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  bus request; held high until ready_o.
REQ-005 SHALL have port ready_o  input-side response, direction output, 1  one-cycle completion pulse.
REQ-006 SHALL have port addr_i  input  19  byte address; bits [1:0] ignored (word aligned).
REQ-007 SHALL have port wstrb_i  input  4  byte write enables; 0000 means read.
REQ-008 SHALL have port write_data_i  input  32  write data; lane n is bits [8n+7:8n].
REQ-009 SHALL have port read_data_o  output  32  registered read data.
REQ-010 SHALL have port mem_addr_o  output  19  SRAM byte address.
REQ-011 SHALL have port mem_dq_i  input  8  SRAM data in.
REQ-012 SHALL have port mem_dq_o  output  8  SRAM data out.
REQ-013 SHALL have port mem_dq_oe_o  output  1  data pad output enable, high = drive.
REQ-014 SHALL have ports mem_ce_n_o, mem_oe_n_o, mem_we_n_o  output  1 each  active-low SRAM strobes.

Function
REQ-015 SHALL implement states IDLE, ACCESS, RECOVER, DONE.
REQ-016 IDLE with valid_i=1 SHALL latch addr_i[18:2], write_data_i, wstrb_i, select the first byte lane (read: lane 0; write: lowest set strobe bit), go to ACCESS.
REQ-017 ACCESS SHALL last exactly ACCESS_CYCLES cycles with mem_ce_n_o=0 and mem_addr_o={latched word, lane[1:0]}.
REQ-018 Read ACCESS SHALL drive mem_oe_n_o=0, mem_we_n_o=1, mem_dq_oe_o=0, and capture mem_dq_i into read_data_o lane on the last ACCESS cycle.
REQ-019 Write ACCESS SHALL drive mem_we_n_o=0, mem_oe_n_o=1, mem_dq_oe_o=1, mem_dq_o=latched lane data.
REQ-020 After a write ACCESS, RECOVER SHALL last 1 cycle: mem_we_n_o=1, mem_ce_n_o=0, address and mem_dq_o/mem_dq_oe_o unchanged.
REQ-021 Read SHALL step lanes 0,1,2,3 back-to-back ACCESS to ACCESS; write SHALL step from RECOVER to next set strobe lane, skipping clear lanes.
REQ-022 After the final lane, DONE SHALL assert ready_o=1 for exactly one cycle with all strobes inactive, then return to IDLE.
REQ-023 New request SHALL NOT be accepted in the DONE cycle; valid_i still high in the following IDLE cycle starts a new transaction.
REQ-024 Read latency (request cycle = 0) SHALL be ready_o in cycle 1+4*ACCESS_CYCLES; write latency SHALL be cycle 1+k*(ACCESS_CYCLES+1), k = popcount(wstrb).
REQ-025 read_data_o SHALL change only during read capture and hold its value across writes and idle.
REQ-026 Inputs other than valid_i SHALL be ignored outside IDLE.
REQ-027 mem_dq_oe_o SHALL never be high while mem_oe_n_o=0.
REQ-028 In IDLE: mem_ce_n_o=mem_oe_n_o=mem_we_n_o=1, mem_dq_oe_o=0.

Reset
REQ-029 rst_i=1 SHALL immediately force state IDLE, ready_o=0, read_data_o=0, mem_addr_o=0, mem_dq_o=0, mem_dq_oe_o=0, all strobes 1.
REQ-030 Reset mid-transaction SHALL abort without a ready_o pulse; the first request after release starts at lane selection.

Verification
REQ-031 Read, ACCESS_CYCLES=2, addr 0x00104, SRAM bytes 0x00104..7 = 11,22,33,44 -> mem_addr_o 0x00104..0x00107 two cycles each, ready_o in cycle 9, read_data_o=0x44332211.
REQ-032 Write 0xDEADBEEF, wstrb=1111, addr 0x7FFFC -> four we_n pulses of 2 cycles separated by 1-cycle RECOVER, bytes EF,BE,AD,DE at 0x7FFFC..F, ready_o in cycle 13.
REQ-033 Write wstrb=0100, data 0x00AB0000, addr 0x00010 -> single we_n pulse at 0x00012 with data 0xAB, ready_o in cycle 4, read_data_o unchanged.
REQ-034 valid_i held high across two reads -> ready_o pulses separated by DONE plus IDLE cycle; no back-to-back ready_o.
REQ-035 rst_i asserted in cycle 5 of a write -> strobes high and dq_oe low same cycle, no ready_o; subsequent read completes normally.
REQ-036 ACCESS_CYCLES=1 read -> ready_o in cycle 5; assertion checks REQ-027 throughout all scenarios.
